// File: rtl/axis_input_sync_pkg.sv
// axis_input_sync_pkg
//   Shared types and width helpers for the conv-input stream join.
//   - sync_state_e : join FSM state (IDLE waits for a config strobe,
//                    RUN merges beats until the weights tlast goes out)
//   - PIX_W / W_W  : per-channel pixel and weights bus widths for the
//                    default geometry
//   - pix_width / wt_width : the same widths for any parameter set
package axis_input_sync_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sync_state_e;

    localparam int unsigned DEF_WORD_WIDTH   = 8;
    localparam int unsigned DEF_UNITS        = 2;
    localparam int unsigned DEF_CORES        = 2;
    localparam int unsigned DEF_KERNEL_W_MAX = 3;

    localparam int unsigned PIX_W = DEF_UNITS * DEF_WORD_WIDTH;
    localparam int unsigned W_W   = DEF_CORES * DEF_KERNEL_W_MAX * DEF_WORD_WIDTH;

    function automatic int unsigned pix_width(input int unsigned units,
                                              input int unsigned word_width);
        return units * word_width;
    endfunction

    function automatic int unsigned wt_width(input int unsigned cores,
                                             input int unsigned kernel_w_max,
                                             input int unsigned word_width);
        return cores * kernel_w_max * word_width;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo
//   Single-clock FIFO with a registered occupancy count and a registered
//   write-ready (not-full) flag.
//   Ports:
//     aclk, aresetn   clock, asynchronous active-low reset
//     wr_valid        write request
//     wr_ready        not full; low during reset, high from the first edge
//                     after release
//     wr_data         write word
//     rd_en           pop request (ignored while empty)
//     rd_data         head word (undefined while empty)
//     empty           no words stored
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             not_full;
    logic             push;
    logic             pop;

    assign wr_ready = not_full;
    assign empty    = (count == '0);
    assign push     = wr_valid && not_full;
    assign pop      = rd_en && !empty;
    assign rd_data  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // not_full is derived from the next count so it is purely registered:
    // a pop at full frees a slot only from the following cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            not_full <= (count_nxt != DEPTH_C);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_input_sync.sv
// axis_input_sync
//   Joins N_PIX pixel AXI-Stream channels and one weights channel into one
//   lockstep conv-input stream. Every input has its own FIFO that fills
//   regardless of FSM state; the output advances only when the weights FIFO
//   and every enabled pixel FIFO hold a beat. Weights define framing.
//   Ports:
//     aclk, aresetn              clock, asynchronous active-low reset
//     cfg_valid/cfg_ready        packet start handshake (ready while IDLE)
//     cfg_pix_mask               enabled pixel channels, latched on handshake
//     s_axis_pixels_*            N_PIX pixel input channels
//     s_axis_weights_*           weights input channel (+ tuser)
//     m_axis_*                   joined output; disabled channels read zero
//     err_last_mismatch          sticky pixel/weights tlast disagreement
//     beat_count                 output handshakes in the current packet
module axis_input_sync
    import axis_input_sync_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned UNITS        = 2,
    parameter int unsigned CORES        = 2,
    parameter int unsigned KERNEL_W_MAX = 3,
    parameter int unsigned N_PIX        = 2,
    parameter int unsigned TUSER_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [N_PIX-1:0]                      cfg_pix_mask,
    input  logic [N_PIX-1:0]                      s_axis_pixels_tvalid,
    output logic [N_PIX-1:0]                      s_axis_pixels_tready,
    input  logic [N_PIX-1:0]                      s_axis_pixels_tlast,
    input  logic [N_PIX*UNITS*WORD_WIDTH-1:0]     s_axis_pixels_tdata,
    input  logic                                  s_axis_weights_tvalid,
    output logic                                  s_axis_weights_tready,
    input  logic                                  s_axis_weights_tlast,
    input  logic [CORES*KERNEL_W_MAX*WORD_WIDTH-1:0] s_axis_weights_tdata,
    input  logic [TUSER_WIDTH-1:0]                s_axis_weights_tuser,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [N_PIX*UNITS*WORD_WIDTH-1:0]     m_axis_pixels_tdata,
    output logic [CORES*KERNEL_W_MAX*WORD_WIDTH-1:0] m_axis_weights_tdata,
    output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic                                  err_last_mismatch,
    output logic [31:0]                           beat_count
);

    localparam int unsigned CH_W = pix_width(UNITS, WORD_WIDTH);
    localparam int unsigned WT_W = wt_width(CORES, KERNEL_W_MAX, WORD_WIDTH);
    localparam int unsigned PF_W = CH_W + 1;
    localparam int unsigned WF_W = WT_W + 1 + TUSER_WIDTH;

    sync_state_e      state;
    logic [N_PIX-1:0] mask;

    logic [N_PIX-1:0] pix_empty;
    logic [N_PIX-1:0] pix_last;
    logic [N_PIX-1:0] pix_pop;
    logic [CH_W-1:0]  pix_data [N_PIX];

    logic                   w_empty;
    logic                   w_last;
    logic                   w_pop;
    logic [WT_W-1:0]        w_data;
    logic [TUSER_WIDTH-1:0] w_user;
    logic [WF_W-1:0]        w_word;

    logic joined;
    logic handshake;
    logic last_mismatch;

    genvar c;
    generate
        for (c = 0; c < N_PIX; c++) begin : g_pix
            logic [PF_W-1:0] rd_word;

            axis_sync_fifo #(
                .WIDTH (PF_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .aclk     (aclk),
                .aresetn  (aresetn),
                .wr_valid (s_axis_pixels_tvalid[c]),
                .wr_ready (s_axis_pixels_tready[c]),
                .wr_data  ({s_axis_pixels_tlast[c], s_axis_pixels_tdata[c*CH_W +: CH_W]}),
                .rd_en    (pix_pop[c]),
                .rd_data  (rd_word),
                .empty    (pix_empty[c])
            );

            assign pix_last[c] = rd_word[PF_W-1];
            assign pix_data[c] = rd_word[CH_W-1:0];
        end
    endgenerate

    axis_sync_fifo #(
        .WIDTH (WF_W),
        .DEPTH (FIFO_DEPTH)
    ) u_weights_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_valid (s_axis_weights_tvalid),
        .wr_ready (s_axis_weights_tready),
        .wr_data  ({s_axis_weights_tuser, s_axis_weights_tlast, s_axis_weights_tdata}),
        .rd_en    (w_pop),
        .rd_data  (w_word),
        .empty    (w_empty)
    );

    assign w_data = w_word[WT_W-1:0];
    assign w_last = w_word[WT_W];
    assign w_user = w_word[WF_W-1 -: TUSER_WIDTH];

    // Disabled channels never gate the join and are never popped, so their
    // prefetched beats stay queued for a later packet.
    assign joined        = !w_empty && ((pix_empty & mask) == '0);
    assign m_axis_tvalid = (state == RUN) && joined;
    assign handshake     = m_axis_tvalid && m_axis_tready;
    assign w_pop         = handshake;
    assign pix_pop       = {N_PIX{handshake}} & mask;
    assign last_mismatch = ((pix_last ^ {N_PIX{w_last}}) & mask) != '0;
    assign cfg_ready     = (state == IDLE);

    // Data is forced to zero whenever no beat is presented so that empty
    // FIFO heads never leak onto the bus.
    always_comb begin
        m_axis_pixels_tdata = '0;
        for (int unsigned i = 0; i < N_PIX; i++) begin
            if (m_axis_tvalid && mask[i]) begin
                m_axis_pixels_tdata[i*CH_W +: CH_W] = pix_data[i];
            end
        end
    end

    assign m_axis_weights_tdata = m_axis_tvalid ? w_data : '0;
    assign m_axis_tuser         = m_axis_tvalid ? w_user : '0;
    assign m_axis_tlast         = m_axis_tvalid && w_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= IDLE;
            mask              <= '0;
            err_last_mismatch <= 1'b0;
            beat_count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        state             <= RUN;
                        mask              <= cfg_pix_mask;
                        err_last_mismatch <= 1'b0;
                        beat_count        <= '0;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        beat_count <= beat_count + 32'd1;
                        if (last_mismatch) err_last_mismatch <= 1'b1;
                        if (w_last)        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_input_sync.sv
module tb_axis_input_sync;

    logic        aclk;
    logic        aresetn;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_pix_mask;
    logic [1:0]  s_axis_pixels_tvalid;
    logic [1:0]  s_axis_pixels_tready;
    logic [1:0]  s_axis_pixels_tlast;
    logic [31:0] s_axis_pixels_tdata;
    logic        s_axis_weights_tvalid;
    logic        s_axis_weights_tready;
    logic        s_axis_weights_tlast;
    logic [47:0] s_axis_weights_tdata;
    logic [15:0] s_axis_weights_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] m_axis_pixels_tdata;
    logic [47:0] m_axis_weights_tdata;
    logic [15:0] m_axis_tuser;
    logic        err_last_mismatch;
    logic [31:0] beat_count;

    int n_cmp = 0;
    int n_bad = 0;
    int idx;
    logic v;

    axis_input_sync #(
        .WORD_WIDTH   (8),
        .UNITS        (2),
        .CORES        (2),
        .KERNEL_W_MAX (3),
        .N_PIX        (2),
        .TUSER_WIDTH  (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .cfg_valid             (cfg_valid),
        .cfg_ready             (cfg_ready),
        .cfg_pix_mask          (cfg_pix_mask),
        .s_axis_pixels_tvalid  (s_axis_pixels_tvalid),
        .s_axis_pixels_tready  (s_axis_pixels_tready),
        .s_axis_pixels_tlast   (s_axis_pixels_tlast),
        .s_axis_pixels_tdata   (s_axis_pixels_tdata),
        .s_axis_weights_tvalid (s_axis_weights_tvalid),
        .s_axis_weights_tready (s_axis_weights_tready),
        .s_axis_weights_tlast  (s_axis_weights_tlast),
        .s_axis_weights_tdata  (s_axis_weights_tdata),
        .s_axis_weights_tuser  (s_axis_weights_tuser),
        .m_axis_tvalid         (m_axis_tvalid),
        .m_axis_tready         (m_axis_tready),
        .m_axis_tlast          (m_axis_tlast),
        .m_axis_pixels_tdata   (m_axis_pixels_tdata),
        .m_axis_weights_tdata  (m_axis_weights_tdata),
        .m_axis_tuser          (m_axis_tuser),
        .err_last_mismatch     (err_last_mismatch),
        .beat_count            (beat_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [15:0] pix_word(input logic [3:0] tag, input logic [3:0] g, input int b);
        return {tag, g, 8'(b)};
    endfunction

    function automatic logic [47:0] w_word(input logic [3:0] g, input int b);
        return {24'hC0FFEE, 4'h0, g, 8'h00, 8'(b)};
    endfunction

    function automatic logic [15:0] user_word(input logic [3:0] g, input int b);
        return {4'h5, g, 8'(b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] g, input int b,
                            input logic [1:0] m, input logic last);
        logic [31:0] ep;
        ep = {m[1] ? pix_word(4'hB, g, b) : 16'h0000,
              m[0] ? pix_word(4'hA, g, b) : 16'h0000};
        chk({tag, "_valid"}, 64'(m_axis_tvalid), 64'(1'b1));
        chk({tag, "_pix"},   64'(m_axis_pixels_tdata), 64'(ep));
        chk({tag, "_wgt"},   64'(m_axis_weights_tdata), 64'(w_word(g, b)));
        chk({tag, "_user"},  64'(m_axis_tuser), 64'(user_word(g, b)));
        chk({tag, "_last"},  64'(m_axis_tlast), 64'(last));
    endtask

    task automatic idle_inputs();
        cfg_valid             = 1'b0;
        s_axis_pixels_tvalid  = '0;
        s_axis_pixels_tlast   = '0;
        s_axis_pixels_tdata   = '0;
        s_axis_weights_tvalid = 1'b0;
        s_axis_weights_tlast  = 1'b0;
        s_axis_weights_tdata  = '0;
        s_axis_weights_tuser  = '0;
    endtask

    task automatic drv(input logic [1:0] pv, input int b0, input int b1, input logic [1:0] pl,
                       input logic wv, input int bw, input logic wl, input logic [3:0] g);
        s_axis_pixels_tvalid  = pv;
        s_axis_pixels_tdata   = {pix_word(4'hB, g, b1), pix_word(4'hA, g, b0)};
        s_axis_pixels_tlast   = pl;
        s_axis_weights_tvalid = wv;
        s_axis_weights_tdata  = w_word(g, bw);
        s_axis_weights_tuser  = user_word(g, bw);
        s_axis_weights_tlast  = wl;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pix_tready"}, 64'(s_axis_pixels_tready), 64'(2'b00));
        chk({tag, "_w_tready"},   64'(s_axis_weights_tready), 64'(1'b0));
        chk({tag, "_cfg_ready"},  64'(cfg_ready), 64'(1'b1));
        chk({tag, "_m_valid"},    64'(m_axis_tvalid), 64'(1'b0));
        chk({tag, "_m_last"},     64'(m_axis_tlast), 64'(1'b0));
        chk({tag, "_m_pix"},      64'(m_axis_pixels_tdata), 64'(0));
        chk({tag, "_m_wgt"},      64'(m_axis_weights_tdata), 64'(0));
        chk({tag, "_m_user"},     64'(m_axis_tuser), 64'(0));
        chk({tag, "_err"},        64'(err_last_mismatch), 64'(1'b0));
        chk({tag, "_bc"},         64'(beat_count), 64'(0));
    endtask

    initial begin
        idle_inputs();
        cfg_pix_mask  = 2'b00;
        m_axis_tready = 1'b1;
        aresetn       = 1'b1;
        #1 aresetn = 1'b0;
        #2;
        chk_reset_state("rst");
        repeat (3) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;
        tick();
        chk("rst_rel_pix_tready", 64'(s_axis_pixels_tready), 64'(2'b11));
        chk("rst_rel_w_tready",   64'(s_axis_weights_tready), 64'(1'b1));

        // mask 01, 8 beats back to back, ch1 never driven
        for (int k = 0; k <= 8; k++) begin
            cfg_pix_mask = 2'b01;
            if (k < 8) drv(2'b01, k, 0, {1'b0, k == 7}, 1'b1, k, k == 7, 4'd1);
            else       idle_inputs();
            cfg_valid = (k == 0);
            #1;
            if (k == 0) begin
                chk("t1_cfg_ready", 64'(cfg_ready), 64'(1'b1));
                chk("t1_idle_valid", 64'(m_axis_tvalid), 64'(1'b0));
            end else begin
                chk_beat("t1", 4'd1, k - 1, 2'b01, (k - 1) == 7);
                chk("t1_bc", 64'(beat_count), 64'(k - 1));
            end
            tick();
        end
        chk("t1_bc_end",    64'(beat_count), 64'(8));
        chk("t1_idle",      64'(cfg_ready), 64'(1'b1));
        chk("t1_valid_end", 64'(m_axis_tvalid), 64'(1'b0));

        // mask 11, ch1 presents a beat only every other cycle
        for (int t = 0; t <= 8; t++) begin
            cfg_pix_mask = 2'b11;
            drv({(t % 2 == 0) && (t < 8), t < 4}, t, t / 2, {(t / 2) == 3, t == 3},
                t < 4, t, t == 3, 4'd2);
            cfg_valid = (t == 0);
            #1;
            if (t >= 1) begin
                if (t % 2 == 1) chk_beat("t2", 4'd2, (t - 1) / 2, 2'b11, ((t - 1) / 2) == 3);
                else            chk("t2_gap_valid", 64'(m_axis_tvalid), 64'(1'b0));
            end
            tick();
        end
        idle_inputs();
        chk("t2_bc",  64'(beat_count), 64'(4));
        chk("t2_err", 64'(err_last_mismatch), 64'(1'b0));
        chk("t2_idle", 64'(cfg_ready), 64'(1'b1));

        // output stalled 20 cycles: inputs fill to depth 4, head stays put
        idx = 0;
        for (int t = 0; t <= 25; t++) begin
            cfg_pix_mask  = 2'b11;
            m_axis_tready = (t >= 20);
            v = (idx < 6);
            drv({v, v}, idx, idx, {2{idx == 5}}, v, idx, idx == 5, 4'd3);
            cfg_valid = (t == 0);
            #1;
            if (t < 20) begin
                chk("t3_pix_tready", 64'(s_axis_pixels_tready), 64'({2{t < 4}}));
                chk("t3_w_tready",   64'(s_axis_weights_tready), 64'(t < 4));
                if (t >= 1) chk_beat("t3_hold", 4'd3, 0, 2'b11, 1'b0);
                else        chk("t3_idle_valid", 64'(m_axis_tvalid), 64'(1'b0));
            end else begin
                chk_beat("t3_drain", 4'd3, t - 20, 2'b11, t == 25);
            end
            if (v && s_axis_weights_tready) idx++;
            tick();
        end
        idle_inputs();
        m_axis_tready = 1'b1;
        chk("t3_bc",   64'(beat_count), 64'(6));
        chk("t3_idle", 64'(cfg_ready), 64'(1'b1));

        // ch0 tlast on beat 3, weights tlast on beat 4
        for (int k = 0; k <= 4; k++) begin
            cfg_pix_mask = 2'b01;
            if (k < 4) drv(2'b01, k, 0, {1'b0, k == 2}, 1'b1, k, k == 3, 4'd4);
            else       idle_inputs();
            cfg_valid = (k == 0);
            #1;
            if (k >= 1) begin
                chk_beat("t4", 4'd4, k - 1, 2'b01, (k - 1) == 3);
                chk("t4_err", 64'(err_last_mismatch), 64'(k >= 4));
            end
            tick();
        end
        chk("t4_err_hold", 64'(err_last_mismatch), 64'(1'b1));
        chk("t4_idle",     64'(cfg_ready), 64'(1'b1));

        // mask 0: weights only; ch0 is fed with a bogus tlast but is ignored
        for (int k = 0; k <= 3; k++) begin
            cfg_pix_mask = 2'b00;
            if (k < 3) drv(2'b01, k, 0, {1'b0, k == 0}, 1'b1, k, k == 2, 4'd5);
            else       idle_inputs();
            cfg_valid = (k == 0);
            #1;
            if (k == 0) begin
                chk("t5_err_before_cfg", 64'(err_last_mismatch), 64'(1'b1));
            end else begin
                chk_beat("t5", 4'd5, k - 1, 2'b00, (k - 1) == 2);
                chk("t5_err", 64'(err_last_mismatch), 64'(1'b0));
            end
            tick();
        end
        chk("t5_bc",  64'(beat_count), 64'(3));
        chk("t5_err_end", 64'(err_last_mismatch), 64'(1'b0));

        // mask 10 packet interrupted by reset on beat 5
        for (int k = 0; k <= 4; k++) begin
            cfg_pix_mask = 2'b10;
            drv(2'b10, 0, k, {k == 7, 1'b0}, 1'b1, k, k == 7, 4'd6);
            cfg_valid = (k == 0);
            #1;
            if (k >= 1) chk_beat("t6_pre", 4'd6, k - 1, 2'b10, 1'b0);
            tick();
        end
        drv(2'b10, 0, 5, 2'b00, 1'b1, 5, 1'b0, 4'd6);
        #1;
        chk_beat("t6_pre", 4'd6, 4, 2'b10, 1'b0);
        chk("t6_pre_bc", 64'(beat_count), 64'(4));
        aresetn = 1'b0;
        #1;
        chk_reset_state("t6_rst");
        idle_inputs();
        @(negedge aclk) aresetn = 1'b1;
        tick();
        chk("t6_rel_pix_tready", 64'(s_axis_pixels_tready), 64'(2'b11));

        // fresh 8-beat packet on both channels; no stale beats may appear
        for (int k = 0; k <= 8; k++) begin
            cfg_pix_mask = 2'b11;
            if (k < 8) drv(2'b11, k, k, {2{k == 7}}, 1'b1, k, k == 7, 4'd7);
            else       idle_inputs();
            cfg_valid = (k == 0);
            #1;
            if (k >= 1) chk_beat("t6_post", 4'd7, k - 1, 2'b11, (k - 1) == 7);
            tick();
        end
        chk("t6_bc",   64'(beat_count), 64'(8));
        chk("t6_err",  64'(err_last_mismatch), 64'(1'b0));
        chk("t6_idle", 64'(cfg_ready), 64'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_input_sync.md
# axis_input_sync

Parametrised successor of the conv input pipe's stream-join stage. It merges N_PIX independent pixel AXI-Stream channels and one weights channel into a single lockstep conv-input stream. Each input has a per-channel FIFO, and pixel channels can be enabled by a runtime mask. Pixel-vs-weights framing mismatches are flagged. It sits between the DMA-facing input streams and the conv engine, generalising the fixed two-pixel-stream (normal / max-pool) arrangement.

## Interface
Parameters:
- WORD_WIDTH, 8, bits per word
- UNITS, 2, words per pixel beat per channel
- CORES, 2, weight cores
- KERNEL_W_MAX, 3, weight words per core per beat
- N_PIX, 2, pixel channels (≥1)
- TUSER_WIDTH, 16, weights tuser width (passed through)
- FIFO_DEPTH, 4, per-channel FIFO depth (power of 2, ≥2)

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset (one clock, reset asynchronous and active-low)
- cfg_valid  in  1  start-of-packet config strobe
- cfg_ready  out  1  high in IDLE
- cfg_pix_mask  in  N_PIX  enabled pixel channels, captured on cfg handshake
- s_axis_pixels_tvalid / tready / tlast  in/out/in  N_PIX each  per-channel handshake
- s_axis_pixels_tdata  in  N_PIX*UNITS*WORD_WIDTH  channel c at bits [c*UNITS*WORD_WIDTH +: UNITS*WORD_WIDTH]
- s_axis_weights_tvalid / tready / tlast  in/out/in  1 each
- s_axis_weights_tdata  in  CORES*KERNEL_W_MAX*WORD_WIDTH
- s_axis_weights_tuser  in  TUSER_WIDTH
- m_axis_tvalid / tready / tlast  out/in/out  1 each
- m_axis_pixels_tdata  out  N_PIX*UNITS*WORD_WIDTH  disabled channels output zero
- m_axis_weights_tdata  out  CORES*KERNEL_W_MAX*WORD_WIDTH
- m_axis_tuser  out  TUSER_WIDTH
- err_last_mismatch  out  1  sticky
- beat_count  out  32  output handshakes in current packet

## Operation
- Each input stream writes its own FIFO (data+tlast[+tuser]) regardless of state (prefetch). s_tready = FIFO not full.
- FSM: IDLE → RUN on cfg_valid&&cfg_ready. In that cycle: latch mask, clear err_last_mismatch, clear beat_count. RUN → IDLE on the output handshake with m_axis_tlast=1. cfg_valid in RUN is ignored.
- In RUN: m_axis_tvalid = weights FIFO non-empty AND every masked pixel FIFO non-empty. On handshake, pop the weights FIFO and all masked pixel FIFOs in the same cycle. Unmasked FIFOs are never popped.
- m_axis_tlast = weights tlast; weights define framing.
- On each handshake, if any masked pixel tlast ≠ weights tlast, set err_last_mismatch; it holds until the next cfg handshake.
- Mask all-zero is legal: weights-only passthrough, pixels zero, err never set.
- beat_count increments per handshake and wraps at 2^32.

## Timing
- Reset (async assert, sync release): FIFOs empty, FSM IDLE, mask 0, m_axis_tvalid 0, all s_tready 0 while aresetn low, 1 on first edge after release. cfg_ready 1, err 0, beat_count 0, data outputs 0.
- Latency: input beat accepted at edge N is presentable at output from cycle N+1, if RUN and all joined FIFOs are non-empty.
- s_tready has no combinational path from m_axis_tready. At full, a simultaneous pop does not enable a push that cycle.
- Simultaneous push and pop on one FIFO leaves occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
- Output data and valid are stable while m_axis_tvalid&&!m_axis_tready.
- Reset mid-packet discards all FIFO contents and returns to IDLE.
- Full throughput: 1 beat/cycle with all valids and tready high.

## Structure
- Package axis_input_sync_pkg: the fsm state enum (IDLE, RUN) and width constants PIX_W=UNITS*WORD_WIDTH and W_W=CORES*KERNEL_W_MAX*WORD_WIDTH.
- Sub-module axis_sync_fifo (parametrised width/depth, registered count, full/empty), instantiated N_PIX+1 times via generate.

## Test plan
- Reset with mask=2'b01, 8-beat packet, all probs 100%: 8 outputs on consecutive cycles; pixels ch0 pass through, ch1 = 0; tlast on beat 8; beat_count=8; FSM returns to IDLE.
- Mask=2'b11, ch1 valid 50% random, ready 100%: output only when both channels are present; data order preserved per channel; no drops.
- m_axis_tready=0 for 20 cycles: each s_tready falls after 4 accepted beats (FIFO_DEPTH=4); output held stable; no loss once ready returns.
- Pixel ch0 tlast on beat 3, weights tlast on beat 4: err_last_mismatch=1 after beat 3, stays set; cleared by next cfg handshake.
- Mask=0, 3-beat weights packet: passthrough, pixels zero, err stays 0.
- aresetn pulled low on beat 5 of 8: outputs return to reset values immediately. A fresh cfg plus 8-beat packet afterwards gives beat_count=8 and no stale data.
